// File: rtl/qupls4_fpu_scheduler_pkg.sv
// Shared types for the FPU scheduler: ROB index/mask types, scheduler state and conveyor stage.
package qupls4_fpu_scheduler_pkg;

   localparam int ROB_ENTRIES = 32;

   typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;
   typedef logic [ROB_ENTRIES-1:0]         rob_bitmask_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ITER = 1'b1
   } fpu_sched_state_t;

   typedef struct packed {
      logic     v;
      logic     kill;
      rob_ndx_t rndx;
   } fpu_conv_stage_t;

endpackage

// File: rtl/qupls4_fpu_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner only when acknowledged.
module qupls4_rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic                     ack,
   output logic [NREQ-1:0]          gnt,
   output logic [$clog2(NREQ)-1:0]  gnt_idx,
   output logic                     any
);

   localparam int SW = $clog2(NREQ);

   logic [SW-1:0] ptr;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[(int'(ptr) + i) % NREQ]) begin
            any                           = 1'b1;
            gnt_idx                       = SW'((int'(ptr) + i) % NREQ);
            gnt[(int'(ptr) + i) % NREQ]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (ack)
         ptr <= (gnt_idx == SW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/qupls4_fpu_scheduler.sv
// Shares one FPU between NREQ stations: round-robin issue, latency conveyor for pipelined ops,
// iterative-op state machine, stomp tracking and writeback. Optional watchdog: QUPLS4_FPU_SCHED_TIMEOUT_EN.
module qupls4_fpu_scheduler
   import qupls4_fpu_scheduler_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int PIPE_LAT = 3,
   parameter int TIMEOUT  = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_iter,
   input  rob_ndx_t                 req_rndx [NREQ],
   input  rob_bitmask_t             stomp,
   input  logic                     fpu_done,
   output logic [NREQ-1:0]          gnt,
   output logic                     fpu_issue,
   output logic [$clog2(NREQ)-1:0]  fpu_sel,
   output logic                     fpu_idle,
   output logic                     wb_v,
   output rob_ndx_t                 wb_rndx,
   output logic                     wb_exc
);

   if (NREQ < 2 || NREQ > 8 || PIPE_LAT < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("qupls4_fpu_scheduler: illegal parameter combination");
   end

   logic [NREQ-1:0]         arb_oh;
   logic [$clog2(NREQ)-1:0] arb_idx;
   logic                    arb_any;

   fpu_sched_state_t state, state_nxt;
   fpu_conv_stage_t  conv [PIPE_LAT];
   fpu_conv_stage_t  push;
   rob_ndx_t         iter_rndx;
   logic             iter_kill;
   logic             conv_empty;
   logic             issue_ok;
   logic             iter_done;
   logic             timeout;

   qupls4_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .ack     (issue_ok),
      .gnt     (arb_oh),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

`ifdef QUPLS4_FPU_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wd_cnt;

   // Counter restarts every time S_ITER is entered; expiry only matters if the FPU stayed silent.
   always_ff @(posedge clk) begin
      if (rst || state != S_ITER)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end

   assign timeout = (state == S_ITER) && (wd_cnt == TW'(TIMEOUT - 1)) && !fpu_done;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      conv_empty = 1'b1;
      for (int i = 0; i < PIPE_LAT; i++)
         if (conv[i].v) conv_empty = 1'b0;
   end

   // An iterative winner stalls the whole arbiter until the conveyor drains, so it cannot be starved.
   always_comb begin
      issue_ok  = !rst && state == S_IDLE && arb_any && (!req_iter[arb_idx] || conv_empty);
      fpu_issue = issue_ok;
      gnt       = issue_ok ? arb_oh : '0;
      fpu_sel   = issue_ok ? arb_idx : '0;
      push      = '0;
      if (issue_ok && !req_iter[arb_idx]) begin
         push.v    = 1'b1;
         push.rndx = req_rndx[arb_idx];
         push.kill = stomp[req_rndx[arb_idx]];
      end
      state_nxt = state;
      iter_done = 1'b0;
      case (state)
         S_IDLE: if (issue_ok && req_iter[arb_idx]) state_nxt = S_ITER;
         S_ITER: if (fpu_done || timeout) begin
            iter_done = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (iter_done) begin
         wb_v    = ~iter_kill;
         wb_rndx = iter_rndx;
         wb_exc  = timeout;
      end else begin
         wb_v    = conv[PIPE_LAT-1].v & ~conv[PIPE_LAT-1].kill;
         wb_rndx = conv[PIPE_LAT-1].rndx;
         wb_exc  = 1'b0;
      end
      fpu_idle = (state == S_IDLE) && conv_empty && !issue_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LAT; i++) conv[i] <= '0;
      end else begin
         conv[0] <= push;
         for (int i = 1; i < PIPE_LAT; i++) begin
            conv[i].v    <= conv[i-1].v;
            conv[i].rndx <= conv[i-1].rndx;
            conv[i].kill <= conv[i-1].kill | stomp[conv[i-1].rndx];
         end
      end
   end

   // The FPU is never aborted; a stomp only marks the running iterative op so its writeback is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         iter_rndx <= '0;
         iter_kill <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && state_nxt == S_ITER) begin
            iter_rndx <= req_rndx[arb_idx];
            iter_kill <= stomp[req_rndx[arb_idx]];
         end else if (state == S_ITER) begin
            iter_kill <= iter_kill | stomp[iter_rndx];
         end
      end
   end

endmodule

// File: tb/tb_qupls4_fpu_scheduler.sv
// Directed self-checking bench for qupls4_fpu_scheduler (NREQ=4, PIPE_LAT=3).
module tb_qupls4_fpu_scheduler;
   import qupls4_fpu_scheduler_pkg::*;

   localparam int NREQ     = 4;
   localparam int PIPE_LAT = 3;
   localparam int TIMEOUT  = 255;

   logic            clk;
   logic            rst;
   logic [3:0]      req;
   logic [3:0]      req_iter;
   rob_ndx_t        req_rndx [NREQ];
   rob_bitmask_t    stomp;
   logic            fpu_done;
   logic [3:0]      gnt;
   logic            fpu_issue;
   logic [1:0]      fpu_sel;
   logic            fpu_idle;
   logic            wb_v;
   rob_ndx_t        wb_rndx;
   logic            wb_exc;

   int checks = 0;
   int errors = 0;

   qupls4_fpu_scheduler #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_iter  (req_iter),
      .req_rndx  (req_rndx),
      .stomp     (stomp),
      .fpu_done  (fpu_done),
      .gnt       (gnt),
      .fpu_issue (fpu_issue),
      .fpu_sel   (fpu_sel),
      .fpu_idle  (fpu_idle),
      .wb_v      (wb_v),
      .wb_rndx   (wb_rndx),
      .wb_exc    (wb_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] it, input logic done,
                                input rob_bitmask_t st);
      @(negedge clk);
      req      = r;
      req_iter = it;
      fpu_done = done;
      stomp    = st;
      #1;
   endtask

   task automatic setRndx(input int a, input int b, input int c, input int d);
      req_rndx[0] = rob_ndx_t'(a);
      req_rndx[1] = rob_ndx_t'(b);
      req_rndx[2] = rob_ndx_t'(c);
      req_rndx[3] = rob_ndx_t'(d);
   endtask

   initial begin
      int exp_gnt [8] = '{1, 2, 4, 8, 1, 0, 0, 0};
      int exp_stn [5] = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      setRndx(0, 0, 0, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("rst_idle", fpu_idle, 1);
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_issue", fpu_issue, 0);
      checkOutput("rst_sel", fpu_sel, 0);
      checkOutput("rst_wbv", wb_v, 0);
      checkOutput("rst_wbrndx", wb_rndx, 0);
      checkOutput("rst_exc", wb_exc, 0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
         checkOutput("quiet_idle", fpu_idle, 1);
         checkOutput("quiet_gnt", gnt, 0);
         checkOutput("quiet_wbv", wb_v, 0);
      end

      $display("[TB] round-robin pipelined issue");
      setRndx(1, 2, 3, 4);
      for (int k = 0; k < 8; k++) begin
         applyStimulus((k < 5) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0, '0);
         checkOutput("rr_gnt", gnt, exp_gnt[k]);
         if (k < 5) checkOutput("rr_sel", fpu_sel, exp_stn[k]);
         if (k >= 3) begin
            checkOutput("rr_wbv", wb_v, 1);
            checkOutput("rr_wbrndx", wb_rndx, exp_stn[k-3] + 1);
         end else begin
            checkOutput("rr_wbv_early", wb_v, 0);
         end
      end

      $display("[TB] stomp of pipelined op");
      setRndx(5, 6, 7, 0);
      applyStimulus(4'b0001, 4'b0000, 1'b0, '0);
      checkOutput("st_gnt0", gnt, 4'b0001);
      applyStimulus(4'b0010, 4'b0000, 1'b0, rob_bitmask_t'(1) << 5);
      checkOutput("st_gnt1", gnt, 4'b0010);
      applyStimulus(4'b0100, 4'b0000, 1'b0, '0);
      checkOutput("st_gnt2", gnt, 4'b0100);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("st_killed", wb_v, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("st_nb1_v", wb_v, 1);
      checkOutput("st_nb1_rndx", wb_rndx, 6);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("st_nb2_v", wb_v, 1);
      checkOutput("st_nb2_rndx", wb_rndx, 7);

      $display("[TB] iterative op waits for empty conveyor");
      setRndx(10, 0, 11, 12);
      applyStimulus(4'b0001, 4'b0000, 1'b0, '0);
      checkOutput("it_pipe_gnt", gnt, 4'b0001);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(4'b1100, 4'b0100, 1'b0, '0);
         checkOutput("it_stall_gnt", gnt, 0);
         if (k == 3) begin
            checkOutput("it_pipe_wbv", wb_v, 1);
            checkOutput("it_pipe_wbrndx", wb_rndx, 10);
         end
      end
      applyStimulus(4'b1100, 4'b0100, 1'b0, '0);
      checkOutput("it_gnt", gnt, 4'b0100);
      checkOutput("it_issue", fpu_issue, 1);
      for (int k = 5; k < 34; k++) begin
         applyStimulus(4'b1000, 4'b0000, 1'b0, '0);
         checkOutput("it_block_gnt", gnt, 0);
         checkOutput("it_busy", fpu_idle, 0);
         checkOutput("it_wait_wbv", wb_v, 0);
      end
      applyStimulus(4'b1000, 4'b0000, 1'b1, '0);
      checkOutput("it_done_wbv", wb_v, 1);
      checkOutput("it_done_rndx", wb_rndx, 11);
      checkOutput("it_done_gnt", gnt, 0);
      applyStimulus(4'b1000, 4'b0000, 1'b0, '0);
      checkOutput("it_resume_gnt", gnt, 4'b1000);
      for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("it_drained", fpu_idle, 1);

      $display("[TB] stomped iterative op and reset mid-op");
      setRndx(0, 9, 0, 0);
      applyStimulus(4'b0010, 4'b0010, 1'b0, '0);
      checkOutput("sti_gnt", gnt, 4'b0010);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, rob_bitmask_t'(1) << 9);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("sti_busy", fpu_idle, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b1, '0);
      checkOutput("sti_wbv", wb_v, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("sti_idle", fpu_idle, 1);
      setRndx(12, 0, 0, 0);
      applyStimulus(4'b0001, 4'b0001, 1'b0, '0);
      checkOutput("rmo_gnt", gnt, 4'b0001);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      rst = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      rst = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("rmo_idle", fpu_idle, 1);
      checkOutput("rmo_gnt0", gnt, 0);
      checkOutput("rmo_wbv", wb_v, 0);
      checkOutput("rmo_wbrndx", wb_rndx, 0);
      checkOutput("rmo_exc", wb_exc, 0);
      applyStimulus(4'b0000, 4'b0000, 1'b1, '0);
      checkOutput("done_in_idle_wbv", wb_v, 0);
      applyStimulus(4'b1111, 4'b0000, 1'b0, '0);
      checkOutput("rmo_ptr_gnt", gnt, 4'b0001);
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 4'b0000, 1'b0, '0);

`ifdef QUPLS4_FPU_SCHED_TIMEOUT_EN
      $display("[TB] watchdog expiry");
      setRndx(20, 0, 0, 0);
      applyStimulus(4'b0001, 4'b0001, 1'b0, '0);
      checkOutput("wd_gnt", gnt, 4'b0001);
      for (int k = 1; k <= TIMEOUT; k++) begin
         applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
         checkOutput("wd_exc", wb_exc, (k == TIMEOUT) ? 1 : 0);
         if (k == TIMEOUT) begin
            checkOutput("wd_wbv", wb_v, 1);
            checkOutput("wd_wbrndx", wb_rndx, 20);
         end
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0, '0);
      checkOutput("wd_idle", fpu_idle, 1);
      checkOutput("wd_exc_clear", wb_exc, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
